// File: rtl/pwm_capture_if.sv
// PWM capture bus: the measured waveform going in and the measurement results coming out.
// The capture block uses the slave side and whoever drives pwmIn uses the master side.
`timescale 1ns/1ps
interface pwm_capture_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  pwmIn;
  logic [DATA_WIDTH-1:0] pwmPeriod;
  logic [DATA_WIDTH-1:0] pwmDutyCycle;
  logic                  valid;
  logic                  stuck;

  modport master (
    output pwmIn,
    input  pwmPeriod,
    input  pwmDutyCycle,
    input  valid,
    input  stuck
  );

  modport slave (
    input  pwmIn,
    output pwmPeriod,
    output pwmDutyCycle,
    output valid,
    output stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM period / high-time capture.
// The asynchronous pwmIn is synchronised. Rising and falling edges drive an IDLE/HIGH/LOW FSM
// that counts the high and low phases. The block reports period and duty on each complete
// rising-to-rising cycle.
// A quiet-time counter raises 'stuck' after 2^DATA_WIDTH-1 cycles without an edge.
// Optional feature: define PWM_CAPTURE_GLITCH_FILTER_EN to insert a 3-sample majority filter
// after the synchroniser. The filter rejects single-cycle pulses and adds two cycles of latency.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int CLK_PERIOD  = 100,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [DATA_WIDTH-1:0] MAX_CNT  = '1;
  localparam logic [DATA_WIDTH-1:0] NEAR_MAX = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Reject configurations that cannot work: a one-flop synchroniser or a nonsensical clock.
  if (SYNC_STAGES < 2 || CLK_PERIOD < 1) begin : gBadParam
    $error("pwm_capture: SYNC_STAGES must be >= 2 and CLK_PERIOD must be positive");
  end

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   syncOut;
  logic                   cleanIn;
  logic                   prevIn;
  logic                   riseEdge;
  logic                   fallEdge;
  logic                   anyEdge;
  logic                   timeoutHit;
  logic [DATA_WIDTH-1:0]  quietCnt;
  logic [DATA_WIDTH-1:0]  highCnt;
  logic [DATA_WIDTH-1:0]  lowCnt;
  logic [DATA_WIDTH:0]    sumWide;
  logic [DATA_WIDTH-1:0]  sumSat;
  logic [DATA_WIDTH-1:0]  periodReg;
  logic [DATA_WIDTH-1:0]  dutyReg;
  logic                   validReg;
  logic                   stuckReg;
  state_t                 state;

  // Shift the raw input through the synchroniser chain to tame metastability.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncReg <= '0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], bus.pwmIn};
    end
  end

  assign syncOut = syncReg[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] filtHist;
  logic       filtReg;

  // Majority vote over the last three synchronised samples, registered. An isolated
  // one-cycle pulse never wins the vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filtHist <= '0;
      filtReg  <= 1'b0;
    end else begin
      filtHist <= {filtHist[0], syncOut};
      filtReg  <= (syncOut & filtHist[0]) | (syncOut & filtHist[1]) | (filtHist[0] & filtHist[1]);
    end
  end

  assign cleanIn = filtReg;
`else
  assign cleanIn = syncOut;
`endif

  // One-cycle-delayed copy of the cleaned input, used for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prevIn <= 1'b0;
    end else begin
      prevIn <= cleanIn;
    end
  end

  assign riseEdge   = cleanIn & ~prevIn;
  assign fallEdge   = ~cleanIn & prevIn;
  assign anyEdge    = riseEdge | fallEdge;
  assign timeoutHit = ~anyEdge && (quietCnt == NEAR_MAX);

  // Add the two phase counts one bit wider, and clamp the period instead of letting it wrap.
  assign sumWide = {1'b0, highCnt} + {1'b0, lowCnt};
  assign sumSat  = sumWide[DATA_WIDTH] ? MAX_CNT : sumWide[DATA_WIDTH-1:0];

  // Count cycles since the last edge. Saturate the count so 'stuck' stays meaningful.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quietCnt <= '0;
    end else if (anyEdge) begin
      quietCnt <= '0;
    end else if (quietCnt != MAX_CNT) begin
      quietCnt <= quietCnt + ONE;
    end
  end

  // Measurement FSM: time the high and low phases, report on each completed rising-to-rising
  // cycle, and drop back to IDLE when the waveform stops moving.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      highCnt   <= '0;
      lowCnt    <= '0;
      periodReg <= '0;
      dutyReg   <= '0;
      validReg  <= 1'b0;
      stuckReg  <= 1'b0;
    end else begin
      validReg <= 1'b0;

      if (anyEdge) begin
        stuckReg <= 1'b0;
      end else if (timeoutHit) begin
        stuckReg <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (riseEdge) begin
            state   <= HIGH;
            highCnt <= ONE;
            lowCnt  <= ONE;
          end
        end
        HIGH: begin
          if (timeoutHit) begin
            state <= IDLE;
          end else if (fallEdge) begin
            state <= LOW;
          end else if (highCnt != MAX_CNT) begin
            highCnt <= highCnt + ONE;
          end
        end
        LOW: begin
          if (timeoutHit) begin
            state <= IDLE;
          end else if (riseEdge) begin
            state     <= HIGH;
            periodReg <= sumSat;
            dutyReg   <= highCnt;
            validReg  <= 1'b1;
            highCnt   <= ONE;
            lowCnt    <= ONE;
          end else if (lowCnt != MAX_CNT) begin
            lowCnt <= lowCnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pwmPeriod    = periodReg;
  assign bus.pwmDutyCycle = dutyReg;
  assign bus.valid        = validReg;
  assign bus.stuck        = stuckReg;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture (DATA_WIDTH=8 so saturation and stuck are reachable).
// A run-length model of the waveform predicts every valid pulse and the held outputs.
// Directed literal checks pin reset, latency, saturation, stuck and glitch behaviour.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CLK_PERIOD  = 100;
  localparam int DATA_WIDTH  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAXV        = (1 << DATA_WIDTH) - 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif

  typedef struct {
    int due;
    int per;
    int duty;
  } report_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pwm_capture_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  pwm_capture #(
    .CLK_PERIOD (CLK_PERIOD),
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  int      cyc = 0;
  report_t expQ[$];
  int      expPer = 0;
  int      expDuty = 0;
  bit      logging = 1'b0;
  int      logPer[$];
  int      logDuty[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    bus.pwmIn = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulses(input int high, input int low, input int count);
    repeat (count) begin
      applyStimulus(1'b1, high);
      applyStimulus(1'b0, low);
    end
  endtask

  // Model: view pwmIn as a sequence of samples, optionally majority-filtered, and derive
  // reports from rise/fall positions. A gap longer than the timeout discards the partial cycle.
  initial begin : model
    bit x0, x1, x2, y, yPrev, haveRise, sawFall;
    int lastRise, fallIdx, lastEdge, n, lat, per;
    x0 = 0; x1 = 0; x2 = 0; yPrev = 0; haveRise = 0; sawFall = 0;
    lastRise = 0; fallIdx = 0; lastEdge = -1;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        x0 = 0; x1 = 0; x2 = 0; yPrev = 0; haveRise = 0; sawFall = 0;
        lastEdge = -1; cyc = 0; expQ.delete(); expPer = 0; expDuty = 0;
      end else begin
        n  = cyc;
        x2 = x1; x1 = x0; x0 = bus.pwmIn;
        if (FILT != 0) begin
          y   = ((int'(x0) + int'(x1) + int'(x2)) >= 2);
          lat = SYNC_STAGES + 1;
        end else begin
          y   = x0;
          lat = SYNC_STAGES;
        end
        if (y != yPrev) begin
          if (n - lastEdge - 1 >= MAXV) begin
            haveRise = 0;
            sawFall  = 0;
          end
          lastEdge = n;
          if (!y && haveRise) begin
            fallIdx = n;
            sawFall = 1;
          end
          if (y) begin
            if (haveRise && sawFall) begin
              per = n - lastRise;
              if (per > MAXV) per = MAXV;
              expQ.push_back('{due: n + lat, per: per, duty: fallIdx - lastRise});
            end
            haveRise = 1;
            lastRise = n;
            sawFall  = 0;
          end
        end
        yPrev = y;
        cyc   = n + 1;
      end
    end
  end

  // Compare process: on every falling clock edge, check the DUT outputs against the model.
  initial begin : compare
    bit dueNow;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("resetValid", bus.valid, 0);
        checkOutput("resetPeriod", bus.pwmPeriod, 0);
        checkOutput("resetDuty", bus.pwmDutyCycle, 0);
        checkOutput("resetStuck", bus.stuck, 0);
      end else begin
        dueNow = (expQ.size() > 0) && (expQ[0].due == cyc - 1);
        if (dueNow) begin
          expPer  = expQ[0].per;
          expDuty = expQ[0].duty;
          void'(expQ.pop_front());
        end
        checkOutput("modelValid", bus.valid, dueNow);
        checkOutput("modelPeriod", bus.pwmPeriod, expPer);
        checkOutput("modelDuty", bus.pwmDutyCycle, expDuty);
        if (logging && bus.valid) begin
          logPer.push_back(int'(bus.pwmPeriod));
          logDuty.push_back(int'(bus.pwmDutyCycle));
        end
      end
    end
  end

  initial begin : watchdog
    #(CLK_PERIOD * 50000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bus.pwmIn = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("initPeriod", bus.pwmPeriod, 0);
    checkOutput("initStuck", bus.stuck, 0);
    rst = 1'b1;
    applyStimulus(1'b0, 4);

    $display("[TB] period 2 / duty 1");
    pulses(1, 1, 10);
    applyStimulus(1'b0, 8);
    checkOutput("p2Period", bus.pwmPeriod, 2);
    checkOutput("p2Duty", bus.pwmDutyCycle, 1);

    $display("[TB] period 4 / duty 1, then period 10 / duty 7");
    pulses(1, 3, 6);
    checkOutput("p4Period", bus.pwmPeriod, 4);
    checkOutput("p4Duty", bus.pwmDutyCycle, 1);
    pulses(7, 3, 3);
    checkOutput("p10Period", bus.pwmPeriod, 10);
    checkOutput("p10Duty", bus.pwmDutyCycle, 7);

    $display("[TB] period sum saturation");
    pulses(150, 150, 2);
    applyStimulus(1'b1, 8);
    checkOutput("satPeriod", bus.pwmPeriod, MAXV);
    checkOutput("satDuty", bus.pwmDutyCycle, 150);
    applyStimulus(1'b0, 20);

    $display("[TB] reset three cycles into a high phase");
    pulses(4, 4, 3);
    applyStimulus(1'b1, 3);
    rst = 1'b0;
    #1;
    checkOutput("midRstPeriod", bus.pwmPeriod, 0);
    checkOutput("midRstDuty", bus.pwmDutyCycle, 0);
    checkOutput("midRstValid", bus.valid, 0);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 4);
    rst = 1'b1;
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    bus.pwmIn = 1'b1;
    repeat (2 + 2 * FILT) @(negedge clk);
    checkOutput("latencyEarly", bus.valid, 0);
    @(negedge clk);
    checkOutput("latencyValid", bus.valid, 1);
    checkOutput("rstPeriod", bus.pwmPeriod, 8);
    checkOutput("rstDuty", bus.pwmDutyCycle, 4);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 10);

    $display("[TB] one-cycle glitch inside a 20-cycle low time");
    pulses(5, 20, 2);
    logging = 1'b1;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 9);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 10);
    logging = 1'b0;
    if (FILT != 0) begin
      checkOutput("glitchCount", logPer.size(), 3);
      for (int i = 0; i < logPer.size(); i++) begin
        checkOutput("glitchPeriod", logPer[i], 25);
        checkOutput("glitchDuty", logDuty[i], 5);
      end
    end else begin
      checkOutput("glitchCount", logPer.size(), 4);
      if (logPer.size() == 4) begin
        checkOutput("glitchPeriod0", logPer[0], 25);
        checkOutput("glitchPeriod1", logPer[1], 15);
        checkOutput("glitchDuty1", logDuty[1], 5);
        checkOutput("glitchPeriod2", logPer[2], 10);
        checkOutput("glitchDuty2", logDuty[2], 1);
        checkOutput("glitchPeriod3", logPer[3], 25);
      end
    end

    $display("[TB] stuck low, stuck high");
    rst = 1'b0;
    applyStimulus(1'b0, 2);
    rst = 1'b1;
    repeat (MAXV - 1) @(negedge clk);
    checkOutput("stuckEarly", bus.stuck, 0);
    @(negedge clk);
    checkOutput("stuckLow", bus.stuck, 1);
    checkOutput("stuckNoValid", bus.valid, 0);
    bus.pwmIn = 1'b1;
    repeat (2 + 2 * FILT) @(negedge clk);
    checkOutput("stuckHold", bus.stuck, 1);
    @(negedge clk);
    checkOutput("stuckClear", bus.stuck, 0);
    applyStimulus(1'b1, 270);
    checkOutput("stuckHigh", bus.stuck, 1);
    applyStimulus(1'b0, 4);
    pulses(3, 3, 3);
    applyStimulus(1'b0, 10);
    checkOutput("afterStuckPeriod", bus.pwmPeriod, 6);
    checkOutput("afterStuckDuty", bus.pwmDutyCycle, 3);
    checkOutput("afterStuckFlag", bus.stuck, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
